// File: rtl/zx_paging_if.sv
// CPU-side bus of the Spectrum 128K/+3 paging controller.
// The CPU bus signals come in on this interface.
// The resolved memory mapping and the register readback go out on it.
interface zx_paging_if #(
    parameter int RAMBITS = 3
);
    logic               ce;
    logic               iorq;
    logic               wr;
    logic [15:0]        a;
    logic [7:0]         d;
    logic               rom;
    logic [1:0]         romPage;
    logic [RAMBITS-1:0] page;
    logic               vpage;
    logic               contend;
    logic               locked;
    logic [7:0]         r7FFD;
    logic [7:0]         r1FFD;

    // The paging controller owns the mapping outputs.
    modport slave (
        input  ce, iorq, wr, a, d,
        output rom, romPage, page, vpage, contend, locked, r7FFD, r1FFD
    );

    // The CPU side drives the bus and observes the mapping.
    modport master (
        output ce, iorq, wr, a, d,
        input  rom, romPage, page, vpage, contend, locked, r7FFD, r1FFD
    );
endinterface

// File: rtl/zx_paging.sv
// Memory paging controller for the 128K / +2A / +3 Spectrum.
// It holds port 7FFD and, when PLUS3 is set, port 1FFD.
// It maps every CPU address to a ROM page or a RAM bank and flags contended banks.
// A port write is taken once per I/O cycle. The write is taken on the first ce
// sample that sees the decode after a sample that did not see it.
module zx_paging #(
    parameter int RAMBITS = 3,
    parameter int PLUS3   = 0
) (
    input  logic        clock,
    input  logic        reset,
    zx_paging_if.slave  bus
);

    logic       sel7;
    logic       sel1;
    logic       wr_prev;
    logic       locked_q;
    logic [7:0] r7_q;
    logic [7:0] r1_q;
    logic       special;
    logic [4:0] bnk;
    logic [2:0] sp_bank;
    logic       rom_c;
    logic [RAMBITS-1:0] page_c;

    // These address lines take no part in the decode for some parameter settings.
    wire unused_ok = &{1'b0, bus.a};

    // Port decode. The +3 decode is tighter so that 1FFD and 7FFD do not alias.
    always_comb begin
        sel7 = 1'b0;
        sel1 = 1'b0;
        if (PLUS3 != 0) begin
            sel7 = !bus.iorq && !bus.wr && (bus.a[15:14] == 2'b01) && !bus.a[1];
            sel1 = !bus.iorq && !bus.wr && (bus.a[15:12] == 4'b0001) && !bus.a[1];
        end else begin
            sel7 = !bus.iorq && !bus.wr && !bus.a[15] && !bus.a[1];
        end
    end

    // Register file, edge detection of the write and the lock latch.
    // Only ce samples count, so a slow I/O cycle that spans many ce pulses
    // still commits only once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_prev  <= 1'b0;
            locked_q <= 1'b0;
            r7_q     <= 8'h00;
            r1_q     <= 8'h00;
        end else if (bus.ce) begin
            wr_prev <= sel7 | sel1;
            if (!wr_prev && !locked_q) begin
                if (sel7) begin
                    r7_q <= bus.d;
                    if (bus.d[5]) locked_q <= 1'b1;
                end
                if (sel1) r1_q <= bus.d;
            end
        end
    end

    assign special = (PLUS3 != 0) && r1_q[0];
    assign bnk     = {r7_q[7], r7_q[6], r7_q[2:0]};

    // Bank for the current quarter in +3 special (all-RAM) mode.
    always_comb begin
        sp_bank = 3'd0;
        case (r1_q[2:1])
            2'b00: sp_bank = {1'b0, bus.a[15:14]};
            2'b01: sp_bank = {1'b1, bus.a[15:14]};
            2'b10: sp_bank = (bus.a[15:14] == 2'b11) ? 3'd3 : {1'b1, bus.a[15:14]};
            default: begin
                case (bus.a[15:14])
                    2'b00:   sp_bank = 3'd4;
                    2'b01:   sp_bank = 3'd7;
                    2'b10:   sp_bank = 3'd6;
                    default: sp_bank = 3'd3;
                endcase
            end
        endcase
    end

    // Address to ROM/RAM mapping. Page is zero while ROM is selected.
    always_comb begin
        rom_c  = 1'b0;
        page_c = '0;
        if (special) begin
            page_c = RAMBITS'(sp_bank);
        end else begin
            case (bus.a[15:14])
                2'b00:   rom_c  = 1'b1;
                2'b01:   page_c = RAMBITS'(3'd5);
                2'b10:   page_c = RAMBITS'(3'd2);
                default: page_c = RAMBITS'(bnk);
            endcase
        end
    end

    assign bus.rom     = rom_c;
    assign bus.page    = page_c;
    assign bus.romPage = (PLUS3 != 0) ? {r1_q[2], r7_q[4]} : {1'b0, r7_q[4]};
    assign bus.vpage   = r7_q[3];
    // The +3 contends banks 4-7; the 128K contends the odd banks.
    assign bus.contend = !rom_c && ((PLUS3 != 0) ? page_c[2] : page_c[0]);
    assign bus.locked  = locked_q;
    assign bus.r7FFD   = r7_q;
    assign bus.r1FFD   = r1_q;

endmodule

// File: doc/zx_paging.md
Name: zx_paging

Overview:
- Memory paging controller for the 128K / +2A / +3 generation of the Spectrum core.
- Holds port 7FFD and, optionally, port 1FFD.
- Maps each CPU address to a ROM page or a physical RAM bank, and flags contended banks.
- Sits between the CPU bus and the memory block; extends the fixed 48K map with parametrised bank count and +3 special paging.

Parameters:
RAMBITS, 3, RAM bank index width; 2^RAMBITS banks; legal 3..5.
PLUS3, 0, 0 = 128K decoding, contention and one ROM select bit; 1 = adds 1FFD, special paging, 2-bit ROM select, +3 contention.

Ports:
clock  in  1  system clock (clock28)
reset  in  1  asynchronous, active-low; clears all state
ce     in  1  port sampling enable (ce7M0n)
iorq   in  1  CPU IORQ, active-low
wr     in  1  CPU WR, active-low
a      in  16  CPU address
d      in  8  CPU data out
rom    out  1  1 = current access maps to ROM
romPage  out  2  ROM page for current access
page   out  RAMBITS  RAM bank for current access; don't-care when rom=1
vpage  out  1  screen bank select: 0 = bank 5, 1 = bank 7
contend  out  1  current address lies in a contended bank
locked  out  1  paging lock state
r7FFD  out  8  register readback
r1FFD  out  8  register readback; 0 when PLUS3=0

Behaviour:
- Registers r7FFD, r1FFD, locked and wrPrev reset asynchronously to 0 on reset low.
- All mapping outputs are combinational from registers and a.
- Decode, PLUS3=0: sel7 = !iorq & !wr & !a[15] & !a[1].
- Decode, PLUS3=1:
  - sel7 = !iorq & !wr & a[15:14]==01 & !a[1].
  - sel1 = !iorq & !wr & a[15:12]==0001 & !a[1].
- Write strobe, sampled only when ce=1:
  - wrPrev <= sel7|sel1.
  - A write commits when the decode is true and wrPrev=0.
  - Exactly one commit per I/O cycle, however many ce pulses the cycle spans.
- Commit when locked=0:
  - sel7: r7FFD <= d.
  - sel1: r1FFD <= d.
  - If sel7 and d[5]=1, locked <= 1 in the same cycle; that write itself still lands.
- Commit when locked=1: ignored for both ports until reset.
- Bank field bnk = {r7FFD[7], r7FFD[6], r7FFD[2:0]}, truncated to RAMBITS LSBs. Bits above RAMBITS are still stored in r7FFD.
- Normal map (special=0, where special = PLUS3 & r1FFD[0]):
  - a[15:14]=00: rom=1.
  - 01: page=5.
  - 10: page=2.
  - 11: page=bnk.
- romPage = PLUS3 ? {r1FFD[2], r7FFD[4]} : {0, r7FFD[4]}.
- Special map (rom=0 for all quarters), by r1FFD[2:1]:
  - 00: banks 0,1,2,3.
  - 01: banks 4,5,6,7.
  - 10: banks 4,5,6,3.
  - 11: banks 4,7,6,3.
- vpage = r7FFD[3].
- contend = !rom & (PLUS3 ? page[2] : page[0]). Only the low 3 bits of page are examined.
- Reset mid-cycle: registers clear immediately. A decode still active after reset release does not commit until wrPrev has been sampled 0 and the next ce sees the decode.
- sel7 and sel1 never both true, by decode construction.

Test Plan:
- After reset, sweep a = 0000/4000/8000/C000 -> rom=1 romPage=0; then page=5, 2, 0; vpage=0, locked=0.
- OUT 7FFD,0x17 with ce pulsed 4x during the IORQ-WR cycle -> single commit, r7FFD=0x17; a=C000 -> page=7, contend=1; romPage=1.
- OUT 7FFD,0x23 then OUT 7FFD,0x05 -> first write lands (page=3, locked=1); second ignored, r7FFD stays 0x23.
- RAMBITS=5: OUT 7FFD,0xC6 -> a=C000 gives page=30 (0x1E), contend=0; RAMBITS=3 gives page=6.
- PLUS3=1: OUT 1FFD,0x07 -> special config 11; a=0000/4000/8000/C000 -> page=4,7,6,3; contend=1,1,1,0; rom=0.
- PLUS3=1: OUT 1FFD,0x04 then OUT 7FFD,0x10 -> a=0000 gives romPage=3; assert reset mid-sequence -> all registers 0, romPage=0.
